// File: rtl/vc_pop_arbiter_pkg.sv
// Shared types and constants for the VC pop arbiter slice.
package vc_arb_pkg;

  // Scheduler state encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } arb_state_e;

  // Width of a VC index (up to four source FIFOs).
  localparam int VC_W = 2;

  // Default source/destination word width.
  localparam int DEFAULT_DATA_W = 12;

  // Width of the saturating burst counter.
  localparam int BURST_CNT_W = 4;

endpackage

// File: rtl/vc_pop_arbiter_if.sv
// Bundle of source-FIFO, destination-FIFO and status signals around the arbiter.
//
// Handshake: a source word is transferred when pop[i] is high for one cycle
// while src_empty[i] was low at the edge that raised it; the arbiter never pops
// an empty source. Downstream there is no ready: out_push is a one-cycle strobe
// and the arbiter stops popping as soon as dst_almost_full is seen high, so the
// words already in flight always fit in the guaranteed free entries.
interface vc_pop_arbiter_if #(
  parameter int NUM_VC = 4,
  parameter int DATA_W = vc_arb_pkg::DEFAULT_DATA_W
);
  import vc_arb_pkg::*;

  logic [NUM_VC-1:0]        src_empty;
  logic [NUM_VC-1:0]        src_almost_empty;
  logic [NUM_VC*DATA_W-1:0] src_data;
  logic                     dst_almost_full;
  logic [NUM_VC-1:0]        pop;
  logic                     out_push;
  logic [DATA_W-1:0]        out_data;
  logic [VC_W-1:0]          out_vc;
  logic                     busy;

  // Arbiter side.
  modport master (
    input  src_empty, src_almost_empty, src_data, dst_almost_full,
    output pop, out_push, out_data, out_vc, busy
  );

  // FIFO / environment side.
  modport slave (
    output src_empty, src_almost_empty, src_data, dst_almost_full,
    input  pop, out_push, out_data, out_vc, busy
  );

endinterface

// File: rtl/vc_pop_arbiter_rr_select.sv
// Combinational rotating-priority picker: first candidate after last_vc.
module rr_select
  import vc_arb_pkg::*;
#(
  parameter int NUM_VC = 4
) (
  input  logic [NUM_VC-1:0] eligible,
  input  logic [VC_W-1:0]   last_vc,
  input  logic [NUM_VC-1:0] exclude,
  output logic              found,
  output logic [VC_W-1:0]   vc
);

  logic [NUM_VC-1:0] cand;

  assign cand = eligible & ~exclude;

  function automatic logic [VC_W-1:0] wrap_vc(input int v);
    return VC_W'(v % NUM_VC);
  endfunction

  // Scan from the farthest position to the nearest so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    vc    = '0;
    for (int k = NUM_VC; k >= 1; k--) begin
      if (cand[wrap_vc(int'(last_vc) + k)]) begin
        found = 1'b1;
        vc    = wrap_vc(int'(last_vc) + k);
      end
    end
  end

endmodule

// File: rtl/vc_pop_arbiter.sv
// Weighted round-robin drain of up to four source FIFOs into one destination FIFO.
module vc_pop_arbiter
  import vc_arb_pkg::*;
#(
  parameter int NUM_VC = 4,
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int BURST  = 4
) (
  input  logic              clk,
  input  logic              reset,
  vc_pop_arbiter_if.master  bus,
  output arb_state_e        dbg_state
);

  arb_state_e             state, state_nxt;
  logic [VC_W-1:0]        grant_vc, grant_vc_nxt;
  logic [VC_W-1:0]        last_vc, last_vc_nxt;
  logic [BURST_CNT_W-1:0] burst_cnt, burst_cnt_nxt;
  logic [NUM_VC-1:0]      pop_q, pop_nxt;

  logic                   s1_valid;
  logic [VC_W-1:0]        s1_vc;
  logic                   out_push_q;
  logic [DATA_W-1:0]      out_data_q;
  logic [VC_W-1:0]        out_vc_q;

  logic [NUM_VC-1:0]      eligible;
  logic [NUM_VC-1:0]      grant_mask;
  logic                   grant_elig;
  logic                   burst_left;
  logic [VC_W-1:0]        sel_last;
  logic [NUM_VC-1:0]      sel_excl;
  logic                   sel_found;
  logic [VC_W-1:0]        sel_vc;
  logic [DATA_W-1:0]      src_word [NUM_VC];

  for (genvar g = 0; g < NUM_VC; g++) begin : g_slice
    assign src_word[g] = bus.src_data[g*DATA_W +: DATA_W];
  end

  // A source being popped this cycle shows pre-pop flags, so its last word
  // must not be popped twice: it also needs almost_empty low.
  assign eligible   = ~bus.src_empty & ~(pop_q & bus.src_almost_empty);
  assign grant_mask = NUM_VC'(1) << grant_vc;
  assign grant_elig = eligible[grant_vc];
  assign burst_left = burst_cnt < BURST_CNT_W'(BURST);

  // From IDLE search after last_vc; when rotating, search after the expiring
  // grant and skip it so another VC gets its turn first.
  assign sel_last = (state == IDLE) ? last_vc : grant_vc;
  assign sel_excl = (state == IDLE) ? '0 : grant_mask;

  rr_select #(.NUM_VC(NUM_VC)) u_rr_select (
    .eligible (eligible),
    .last_vc  (sel_last),
    .exclude  (sel_excl),
    .found    (sel_found),
    .vc       (sel_vc)
  );

  // Next-state and next-pop decision.
  always_comb begin
    state_nxt     = state;
    grant_vc_nxt  = grant_vc;
    last_vc_nxt   = last_vc;
    burst_cnt_nxt = burst_cnt;
    pop_nxt       = '0;
    case (state)
      IDLE: begin
        if (!bus.dst_almost_full && sel_found) begin
          state_nxt     = GRANT;
          grant_vc_nxt  = sel_vc;
          burst_cnt_nxt = BURST_CNT_W'(1);
          pop_nxt       = NUM_VC'(1) << sel_vc;
        end
      end
      GRANT, HOLD: begin
        if (bus.dst_almost_full) begin
          // Backpressure wins over burst expiry; rotation happens on resume.
          state_nxt = HOLD;
        end else if (burst_left && grant_elig) begin
          state_nxt     = GRANT;
          pop_nxt       = grant_mask;
          burst_cnt_nxt = (burst_cnt == '1) ? burst_cnt : burst_cnt + BURST_CNT_W'(1);
        end else begin
          last_vc_nxt = grant_vc;
          if (sel_found) begin
            state_nxt     = GRANT;
            grant_vc_nxt  = sel_vc;
            burst_cnt_nxt = BURST_CNT_W'(1);
            pop_nxt       = NUM_VC'(1) << sel_vc;
          end else if (grant_elig) begin
            // Nobody else wants the slot: start a fresh burst without a bubble.
            state_nxt     = GRANT;
            burst_cnt_nxt = BURST_CNT_W'(1);
            pop_nxt       = grant_mask;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Scheduler state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      grant_vc  <= '0;
      last_vc   <= VC_W'(NUM_VC - 1);
      burst_cnt <= '0;
      pop_q     <= '0;
    end else begin
      state     <= state_nxt;
      grant_vc  <= grant_vc_nxt;
      last_vc   <= last_vc_nxt;
      burst_cnt <= burst_cnt_nxt;
      pop_q     <= pop_nxt;
    end
  end

  // Two-stage capture: pop -> stage-1 tag -> registered push to destination.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid   <= 1'b0;
      s1_vc      <= '0;
      out_push_q <= 1'b0;
      out_data_q <= '0;
      out_vc_q   <= '0;
    end else begin
      s1_valid   <= |pop_q;
      s1_vc      <= grant_vc;
      out_push_q <= s1_valid;
      if (s1_valid) begin
        out_data_q <= src_word[s1_vc];
        out_vc_q   <= s1_vc;
      end
    end
  end

  assign bus.pop      = pop_q;
  assign bus.out_push = out_push_q;
  assign bus.out_data = out_data_q;
  assign bus.out_vc   = out_vc_q;
  assign bus.busy     = (state != IDLE) | s1_valid | out_push_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// Bench for vc_pop_arbiter: emulated source FIFOs, reference scheduler, scoreboard.
module tb_vc_pop_arbiter;
  import vc_arb_pkg::*;

  localparam int NUM_VC = 4;
  localparam int DATA_W = 12;
  localparam int BURST  = 4;
  localparam int DEPTH  = 8;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  vc_pop_arbiter_if #(.NUM_VC(NUM_VC), .DATA_W(DATA_W)) bus ();
  arb_state_e dbg_state;

  vc_pop_arbiter #(.NUM_VC(NUM_VC), .DATA_W(DATA_W), .BURST(BURST)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- environment: source FIFOs ----------------
  logic [DATA_W-1:0] fifo_q [NUM_VC][$];
  logic [DATA_W-1:0] dout [NUM_VC];
  int                pend [NUM_VC];

  // ---------------- reference scheduler + scoreboard ----------------
  bit                m_active;      // a VC currently holds the grant (running or paused)
  int                m_grant;       // VC holding the grant
  int                m_used;        // pops spent in the current burst
  int                m_last;        // VC whose turn ended most recently
  logic [NUM_VC-1:0] m_pop;         // pop expected in the current cycle
  bit                m_s1;          // a word was popped last cycle
  logic [NUM_VC-1:0] pop_prev;      // pop the FIFOs apply at the next edge
  logic [DATA_W+1:0] exp_q [$];     // {vc, data} words expected downstream

  task automatic model_reset();
    m_active = 1'b0;
    m_grant  = 0;
    m_used   = 0;
    m_last   = NUM_VC - 1;
    m_pop    = '0;
    m_s1     = 1'b0;
    pop_prev = '0;
    exp_q.delete();
    for (int i = 0; i < NUM_VC; i++) begin
      fifo_q[i].delete();
      dout[i] = '0;
      pend[i] = 0;
    end
  endtask

  task automatic drive_flags();
    logic [NUM_VC-1:0]        e, ae;
    logic [NUM_VC*DATA_W-1:0] d;
    for (int i = 0; i < NUM_VC; i++) begin
      e[i]  = (fifo_q[i].size() == 0);
      ae[i] = (fifo_q[i].size() <= 1);
      d[i*DATA_W +: DATA_W] = dout[i];
    end
    bus.src_empty        = e;
    bus.src_almost_empty = ae;
    bus.src_data         = d;
  endtask

  // A VC may be popped if it holds a word not already claimed by this cycle's pop.
  function automatic bit can_pop(int i);
    int avail;
    avail = fifo_q[i].size();
    if (m_pop[i] && avail <= 1) return 1'b0;
    return avail > 0;
  endfunction

  function automatic int next_vc(int after, int skip);
    for (int k = 1; k <= NUM_VC; k++) begin
      int v;
      v = (after + k) % NUM_VC;
      if (v != skip && can_pop(v)) return v;
    end
    return -1;
  endfunction

  // Predict the pop for the next cycle from the scheduling rules.
  task automatic model_next(input bit afull);
    logic [NUM_VC-1:0] np;
    int v;
    np = '0;
    if (!m_active) begin
      v = next_vc(m_last, -1);
      if (!afull && v >= 0) begin
        m_active = 1'b1;
        m_grant  = v;
        m_used   = 1;
        np[v]    = 1'b1;
      end
    end else if (!afull) begin
      if (m_used < BURST && can_pop(m_grant)) begin
        m_used++;
        np[m_grant] = 1'b1;
      end else begin
        m_last = m_grant;
        v = next_vc(m_grant, m_grant);
        if (v < 0 && can_pop(m_grant)) v = m_grant;
        if (v >= 0) begin
          m_grant = v;
          m_used  = 1;
          np[v]   = 1'b1;
        end else begin
          m_active = 1'b0;
        end
      end
    end
    m_pop = np;
  endtask

  task automatic load(input int vc, input int n);
    pend[vc] += n;
  endtask

  // One clock: check the cycle, advance the FIFOs, drive inputs, predict.
  task automatic step(input bit afull);
    logic [DATA_W+1:0] got, want;
    bit                exp_busy, exp_push;
    @(negedge clk);
    exp_push = (exp_q.size() != 0);
    exp_busy = m_active || m_s1 || exp_push;
    checks++;
    if (bus.pop !== m_pop) begin
      errors++;
      $display("FAIL pop @%0t: got %b expected %b", $time, bus.pop, m_pop);
    end
    checks++;
    if (bus.busy !== exp_busy) begin
      errors++;
      $display("FAIL busy @%0t: got %b expected %b", $time, bus.busy, exp_busy);
    end
    checks++;
    if (bus.out_push !== exp_push) begin
      errors++;
      $display("FAIL out_push @%0t: got %b expected %b", $time, bus.out_push, exp_push);
      if (exp_push) void'(exp_q.pop_front());
    end else if (exp_push) begin
      want = exp_q.pop_front();
      got  = {bus.out_vc, bus.out_data};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL out_word @%0t: got vc=%0d data=%h expected vc=%0d data=%h",
                 $time, got[DATA_W+1:DATA_W], got[DATA_W-1:0],
                 want[DATA_W+1:DATA_W], want[DATA_W-1:0]);
      end
    end
    for (int i = 0; i < NUM_VC; i++) begin
      if (pop_prev[i]) begin
        checks++;
        if (fifo_q[i].size() == 0) begin
          errors++;
          $display("FAIL pop_empty @%0t: vc=%0d popped with occupancy 0 (required >0)", $time, i);
        end else begin
          dout[i] = fifo_q[i].pop_front();
          exp_q.push_back({VC_W'(i), dout[i]});
        end
      end
    end
    m_s1     = (m_pop != 0);
    pop_prev = bus.pop;
    for (int i = 0; i < NUM_VC; i++) begin
      while (pend[i] > 0 && fifo_q[i].size() < DEPTH) begin
        fifo_q[i].push_back(DATA_W'($urandom_range(0, (1 << DATA_W) - 1)));
        pend[i]--;
      end
      pend[i] = 0;
    end
    bus.dst_almost_full = afull;
    drive_flags();
    model_next(afull);
  endtask

  function automatic bit all_quiet();
    for (int i = 0; i < NUM_VC; i++)
      if (fifo_q[i].size() != 0 || pend[i] != 0) return 1'b0;
    return !m_active && !m_s1 && m_pop == 0 && pop_prev == 0 && exp_q.size() == 0;
  endfunction

  task automatic drain();
    int n;
    n = 0;
    while (!all_quiet() && n < 300) begin
      step(1'b0);
      n++;
    end
    checks++;
    if (!all_quiet()) begin
      errors++;
      $display("FAIL drain_timeout: still active after %0d cycles (required idle)", n);
    end
    step(1'b0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.dst_almost_full = 1'b0;
    drive_flags();
    model_next(1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < NUM_VC; i++) begin
      fifo_q[i].push_back(DATA_W'($urandom_range(0, 4095)));
      fifo_q[i].push_back(DATA_W'($urandom_range(0, 4095)));
    end
    drive_flags();
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checks++;
      if ({bus.pop, bus.out_push, bus.out_data, bus.out_vc, bus.busy} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got pop=%b push=%b data=%h vc=%0d busy=%b required all 0",
                 bus.pop, bus.out_push, bus.out_data, bus.out_vc, bus.busy);
      end
    end
    release_reset();
    step(1'b0);
    checks++;
    if (bus.pop !== 4'b0001) begin
      errors++;
      $display("FAIL first_pop: got %b required 0001", bus.pop);
    end
    step(1'b0);
    step(1'b0);
    checks++;
    if (bus.out_push !== 1'b1 || bus.out_vc !== 2'd0) begin
      errors++;
      $display("FAIL first_push: got push=%b vc=%0d required push=1 vc=0", bus.out_push, bus.out_vc);
    end
    drain();
  endtask

  task automatic test_single_vc_burst();
    int pushes;
    logic [NUM_VC-1:0] exp;
    pushes = 0;
    load(0, 6);
    step(1'b0);
    for (int n = 0; n < 10; n++) begin
      step(1'b0);
      exp = (n < 6) ? 4'b0001 : 4'b0000;
      checks++;
      if (bus.pop !== exp) begin
        errors++;
        $display("FAIL single_vc_seq[%0d]: got %b required %b", n, bus.pop, exp);
      end
      if (bus.out_push === 1'b1) begin
        pushes++;
        checks++;
        if (bus.out_vc !== 2'd0) begin
          errors++;
          $display("FAIL single_vc_tag: got vc=%0d required 0", bus.out_vc);
        end
      end
    end
    checks++;
    if (pushes != 6) begin
      errors++;
      $display("FAIL single_vc_pushes: got %0d required 6", pushes);
    end
    drain();
  endtask

  task automatic test_alternate();
    int tags [$];
    logic [NUM_VC-1:0] exp;
    load(1, 8);
    load(2, 8);
    step(1'b0);
    for (int n = 0; n < 20; n++) begin
      step(1'b0);
      exp = (n < 16) ? (((n / BURST) % 2 == 1) ? 4'b0100 : 4'b0010) : 4'b0000;
      checks++;
      if (bus.pop !== exp) begin
        errors++;
        $display("FAIL alternate_seq[%0d]: got %b required %b", n, bus.pop, exp);
      end
      if (bus.out_push === 1'b1) tags.push_back(int'(bus.out_vc));
    end
    checks++;
    if (tags.size() != 16) begin
      errors++;
      $display("FAIL alternate_count: got %0d pushes required 16", tags.size());
    end else begin
      for (int n = 0; n < 16; n++) begin
        checks++;
        if (tags[n] != (((n / BURST) % 2 == 1) ? 2 : 1)) begin
          errors++;
          $display("FAIL alternate_tag[%0d]: got %0d required %0d", n, tags[n],
                   ((n / BURST) % 2 == 1) ? 2 : 1);
        end
      end
    end
    drain();
  endtask

  task automatic test_single_word();
    int pushes, vc3;
    logic [NUM_VC-1:0] exp;
    pushes = 0;
    vc3    = 0;
    load(3, 1);
    step(1'b0);
    for (int n = 0; n < 6; n++) begin
      step(1'b0);
      exp = (n == 0) ? 4'b1000 : 4'b0000;
      checks++;
      if (bus.pop !== exp) begin
        errors++;
        $display("FAIL single_word_seq[%0d]: got %b required %b", n, bus.pop, exp);
      end
      if (bus.out_push === 1'b1) begin
        pushes++;
        if (bus.out_vc === 2'd3) vc3++;
      end
    end
    checks++;
    if (pushes != 1 || vc3 != 1) begin
      errors++;
      $display("FAIL single_word_push: got pushes=%0d vc3=%0d required 1 and 1", pushes, vc3);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [NUM_VC-1:0] exp_tab [8];
    int pushes;
    exp_tab = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b1000};
    pushes = 0;
    load(2, 8);
    load(3, 4);
    step(1'b0);
    for (int n = 0; n < 8; n++) begin
      step(n >= 1 && n <= 3);
      checks++;
      if (bus.pop !== exp_tab[n]) begin
        errors++;
        $display("FAIL backpressure_seq[%0d]: got %b required %b", n, bus.pop, exp_tab[n]);
      end
      if (n >= 2 && n <= 4 && bus.out_push === 1'b1) pushes++;
    end
    checks++;
    if (pushes != 2) begin
      errors++;
      $display("FAIL backpressure_inflight: got %0d pushes during hold required 2", pushes);
    end
    drain();
  endtask

  task automatic test_reset_in_flight();
    int pushes;
    pushes = 0;
    load(1, 6);
    step(1'b0);
    for (int n = 0; n < 3; n++) step(1'b0);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (bus.pop !== '0 || bus.out_push !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got pop=%b push=%b busy=%b required 0 0 0",
               bus.pop, bus.out_push, bus.busy);
    end
    model_reset();
    drive_flags();
    repeat (2) @(negedge clk);
    release_reset();
    for (int n = 0; n < 5; n++) begin
      step(1'b0);
      if (bus.out_push === 1'b1) pushes++;
    end
    checks++;
    if (pushes != 0) begin
      errors++;
      $display("FAIL push_after_reset: got %0d pushes required 0", pushes);
    end
    load(0, 2);
    drain();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NUM_VC; i++)
        if ($urandom_range(0, 5) == 0) load(i, $urandom_range(1, 4));
      step($urandom_range(0, 4) == 0);
    end
    drain();
  endtask

  initial begin
    bus.dst_almost_full = 1'b0;
    model_reset();
    drive_flags();
    test_reset();
    test_single_vc_burst();
    test_alternate();
    test_single_word();
    test_backpressure();
    test_reset_in_flight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
